// File: rtl/drp_pkg.sv
// Shared constants, address map and FSM state type for the DRP sample responder.
package drp_pkg;

   localparam int unsigned DRP_ADDR_W = 7;
   localparam int unsigned DRP_DATA_W = 16;
   localparam int unsigned SAMPLE_W   = 12;
   localparam int unsigned CHAN_W     = 4;
   localparam int unsigned NUM_VAUX   = 16;
   localparam int unsigned NUM_CFG    = 3;
   localparam int unsigned CFG_IDX_W  = 2;
   localparam int unsigned VAUX_PAD_W = DRP_DATA_W - SAMPLE_W;
   localparam int unsigned OVL_CNT_W  = 8;
   localparam int unsigned LAT_CNT_W  = 4;
   localparam int unsigned LAT_MIN    = 1;
   localparam int unsigned LAT_MAX    = 15;

   localparam logic [DRP_ADDR_W-1:0] DRP_ADDR_VAUX_BASE = 7'h10;
   localparam logic [DRP_ADDR_W-1:0] DRP_ADDR_STATUS    = 7'h3F;
   localparam logic [DRP_ADDR_W-1:0] DRP_ADDR_CFG0      = 7'h40;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } drp_state_t;

   // VAUX results occupy the aligned 16-entry block starting at the base
   function automatic logic is_vaux(input logic [DRP_ADDR_W-1:0] addr);
      return addr[DRP_ADDR_W-1:CHAN_W] == DRP_ADDR_VAUX_BASE[DRP_ADDR_W-1:CHAN_W];
   endfunction

   function automatic logic is_cfg(input logic [DRP_ADDR_W-1:0] addr);
      return (addr >= DRP_ADDR_CFG0) &&
             (addr < (DRP_ADDR_CFG0 + DRP_ADDR_W'(NUM_CFG)));
   endfunction

   function automatic logic [CFG_IDX_W-1:0] cfg_idx(input logic [DRP_ADDR_W-1:0] addr);
      logic [DRP_ADDR_W-1:0] off;
      off = addr - DRP_ADDR_CFG0;
      return off[CFG_IDX_W-1:0];
   endfunction

endpackage

// File: rtl/drp_if.sv
// DRP request/response bundle between a DRP master and the responder.
interface drp_if;
   import drp_pkg::*;

   logic                  den_in;
   logic                  dwe_in;
   logic [DRP_ADDR_W-1:0] daddr_in;
   logic [DRP_DATA_W-1:0] di_in;
   logic [DRP_DATA_W-1:0] do_out;
   logic                  drdy_out;

   modport master (
      output den_in, dwe_in, daddr_in, di_in,
      input  do_out, drdy_out
   );

   modport slave (
      input  den_in, dwe_in, daddr_in, di_in,
      output do_out, drdy_out
   );

endinterface

// File: rtl/drp_regfile.sv
// VAUX result, CONFIG and STATUS storage with combinational read decode.
module drp_regfile
   import drp_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DRP_ADDR_W-1:0] rd_addr,
   output logic [DRP_DATA_W-1:0] rd_data_c,
   input  logic                  wr_en,
   input  logic [DRP_ADDR_W-1:0] wr_addr,
   input  logic [DRP_DATA_W-1:0] wr_data,
   input  logic                  sample_valid,
   input  logic [CHAN_W-1:0]     sample_chan,
   input  logic [SAMPLE_W-1:0]   sample_data,
   input  logic                  overlap
);

   logic [SAMPLE_W-1:0]   vaux_q [NUM_VAUX];
   logic [DRP_DATA_W-1:0] cfg_q  [NUM_CFG];
   logic                  ovl_err_q;
   logic [OVL_CNT_W-1:0]  ovl_cnt_q;

   logic status_clr_c;

   assign status_clr_c = wr_en && (wr_addr == DRP_ADDR_STATUS) && wr_data[0];

   // Read decode; unmapped addresses read as zero
   always_comb begin
      rd_data_c = '0;
      if (is_vaux(rd_addr)) begin
         rd_data_c = {vaux_q[rd_addr[CHAN_W-1:0]], VAUX_PAD_W'(0)};
      end else if (is_cfg(rd_addr)) begin
         rd_data_c = cfg_q[cfg_idx(rd_addr)];
      end else if (rd_addr == DRP_ADDR_STATUS) begin
         rd_data_c = {ovl_cnt_q, 7'h00, ovl_err_q};
      end
   end

   // Result registers are fed only by the sample stream; DRP writes to them are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_VAUX); i++) begin
            vaux_q[i] <= '0;
         end
      end else if (sample_valid) begin
         vaux_q[sample_chan] <= sample_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_CFG); i++) begin
            cfg_q[i] <= '0;
         end
      end else if (wr_en && is_cfg(wr_addr)) begin
         cfg_q[cfg_idx(wr_addr)] <= wr_data;
      end
   end

   // Clear and overlap cannot coincide: an overlap cycle never accepts a write
   always_ff @(posedge clk) begin
      if (reset) begin
         ovl_err_q <= 1'b0;
         ovl_cnt_q <= '0;
      end else if (status_clr_c) begin
         ovl_err_q <= 1'b0;
         ovl_cnt_q <= '0;
      end else if (overlap) begin
         ovl_err_q <= 1'b1;
         if (ovl_cnt_q != '1) begin
            ovl_cnt_q <= ovl_cnt_q + OVL_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/drp_sample_responder.sv
// DRP responder: fixed-latency completion of reads/writes against the sample-fed register file.
module drp_sample_responder
   import drp_pkg::*;
#(
   parameter int unsigned LATENCY = 4
) (
   input  logic                clk,
   input  logic                reset,
   drp_if.slave                drp,
   input  logic                sample_valid,
   input  logic [CHAN_W-1:0]   sample_chan,
   input  logic [SAMPLE_W-1:0] sample_data
);

   localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 1);

   drp_state_t            state_q, state_d;
   logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
   logic                  drdy_q, drdy_d;
   logic [DRP_DATA_W-1:0] snap_q;
   logic [DRP_DATA_W-1:0] do_q;

   logic                  done_c;
   logic                  accept_c;
   logic                  overlap_c;
   logic                  wr_en_c;
   logic [DRP_DATA_W-1:0] rd_data_c;
   logic [DRP_DATA_W-1:0] snap_c;

   // The completion cycle can accept a new request, so it is not an overlap
   assign done_c    = (state_q == ST_BUSY) && (cnt_q == '0);
   assign accept_c  = drp.den_in && ((state_q == ST_IDLE) || done_c);
   assign overlap_c = drp.den_in && (state_q == ST_BUSY) && !done_c;
   assign wr_en_c   = accept_c && drp.dwe_in;
   assign snap_c    = drp.dwe_in ? '0 : rd_data_c;

   drp_regfile u_regfile (
      .clk          (clk),
      .reset        (reset),
      .rd_addr      (drp.daddr_in),
      .rd_data_c    (rd_data_c),
      .wr_en        (wr_en_c),
      .wr_addr      (drp.daddr_in),
      .wr_data      (drp.di_in),
      .sample_valid (sample_valid),
      .sample_chan  (sample_chan),
      .sample_data  (sample_data),
      .overlap      (overlap_c)
   );

   // Next-state and latency counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_BUSY: begin
            if (done_c) begin
               if (accept_c) begin
                  cnt_d = CNT_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - LAT_CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      drdy_d = (state_d == ST_BUSY) && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drdy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drdy_q  <= drdy_d;
      end
   end

   // Snapshot at acceptance; with LATENCY=1 the response leaves in the very next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q <= '0;
         do_q   <= '0;
      end else begin
         if (accept_c) begin
            snap_q <= snap_c;
         end
         if (drdy_d) begin
            do_q <= accept_c ? snap_c : snap_q;
         end
      end
   end

   assign drp.do_out   = do_q;
   assign drp.drdy_out = drdy_q;

endmodule

// File: tb/tb_drp_sample_responder.sv
// Directed bench for drp_sample_responder with a transaction-level reference model.
module tb_drp_sample_responder;
   import drp_pkg::*;

   localparam int unsigned L0 = 4;
   localparam int unsigned L1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sv0, sv1;
   logic [3:0]  sc0, sc1;
   logic [11:0] sd0, sd1;

   drp_if drp0 ();
   drp_if drp1 ();

   drp_sample_responder #(.LATENCY(L0)) dut0 (
      .clk(clk), .reset(reset), .drp(drp0.slave),
      .sample_valid(sv0), .sample_chan(sc0), .sample_data(sd0)
   );

   drp_sample_responder #(.LATENCY(L1)) dut1 (
      .clk(clk), .reset(reset), .drp(drp1.slave),
      .sample_valid(sv1), .sample_chan(sc1), .sample_data(sd1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model of dut0: register map contents and outstanding request as a due cycle
   logic [11:0] m_vaux [16];
   logic [15:0] m_cfg  [3];
   logic        m_err;
   int          m_ovl;
   int          m_cyc = 0;
   bit          m_pend = 0;
   int          m_due = 0;
   logic [15:0] m_snap = '0;
   logic [15:0] exp_do = '0;
   logic        exp_drdy = 1'b0;
   bit          m_started = 0;

   function automatic logic [15:0] m_read(input logic [6:0] a);
      if (a >= 7'h10 && a <= 7'h1F) return {m_vaux[int'(a) - 16], 4'h0};
      if (a >= 7'h40 && a <= 7'h42) return m_cfg[int'(a) - 64];
      if (a == 7'h3F) return {8'(m_ovl), 7'h00, m_err};
      return 16'h0000;
   endfunction

   always @(posedge clk) begin
      bit done, acc, ovl;
      if (reset) begin
         for (int i = 0; i < 16; i++) m_vaux[i] = '0;
         for (int i = 0; i < 3; i++)  m_cfg[i] = '0;
         m_err = 0; m_ovl = 0; m_pend = 0;
         exp_do = '0; exp_drdy = 0;
      end else begin
         done = m_pend && (m_due == m_cyc);
         acc  = drp0.den_in && (!m_pend || done);
         ovl  = drp0.den_in && m_pend && !done;
         if (done) m_pend = 0;
         if (acc) begin
            m_pend = 1;
            m_due  = m_cyc + int'(L0);
            m_snap = drp0.dwe_in ? 16'h0000 : m_read(drp0.daddr_in);
            if (drp0.dwe_in) begin
               if (drp0.daddr_in >= 7'h40 && drp0.daddr_in <= 7'h42)
                  m_cfg[int'(drp0.daddr_in) - 64] = drp0.di_in;
               if (drp0.daddr_in == 7'h3F && drp0.di_in[0]) begin
                  m_err = 0; m_ovl = 0;
               end
            end
         end
         if (ovl) begin
            m_err = 1;
            if (m_ovl < 255) m_ovl++;
         end
         if (sv0) m_vaux[sc0] = sd0;
         exp_drdy = m_pend && (m_due == m_cyc + 1);
         if (exp_drdy) exp_do = m_snap;
      end
      m_cyc++;
      m_started = 1;
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("model drdy_out", 32'(drp0.drdy_out), 32'(exp_drdy));
         check("model do_out", 32'(drp0.do_out), 32'(exp_do));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic en, input logic we,
                        input logic [6:0] a, input logic [15:0] d);
      if (sel == 0) begin
         drp0.den_in = en; drp0.dwe_in = we; drp0.daddr_in = a; drp0.di_in = d;
      end else begin
         drp1.den_in = en; drp1.dwe_in = we; drp1.daddr_in = a; drp1.di_in = d;
      end
   endtask

   task automatic samp(input int sel, input logic v, input logic [3:0] ch, input logic [11:0] d);
      if (sel == 0) begin sv0 = v; sc0 = ch; sd0 = d; end
      else          begin sv1 = v; sc1 = ch; sd1 = d; end
   endtask

   function automatic logic drdy(input int sel);
      return (sel == 0) ? drp0.drdy_out : drp1.drdy_out;
   endfunction

   function automatic logic [15:0] dout(input int sel);
      return (sel == 0) ? drp0.do_out : drp1.do_out;
   endfunction

   // Issue one request (optionally with a same-cycle sample) and wait for its completion
   task automatic txn(input int sel, input logic we, input logic [6:0] a, input logic [15:0] d,
                      input logic [15:0] exp, input int lat, input string name,
                      input logic s_v = 1'b0, input logic [3:0] s_ch = 4'h0,
                      input logic [11:0] s_d = 12'h000);
      int n;
      drive(sel, 1'b1, we, a, d);
      samp(sel, s_v, s_ch, s_d);
      tick();
      drive(sel, 1'b0, 1'b0, 7'h00, 16'h0000);
      samp(sel, 1'b0, 4'h0, 12'h000);
      n = 1;
      while (!drdy(sel) && n < 32) begin
         tick();
         n++;
      end
      check({name, " latency"}, 32'(n), 32'(lat));
      check({name, " data"}, 32'(dout(sel)), 32'(exp));
   endtask

   task automatic load(input int sel, input logic [3:0] ch, input logic [11:0] d);
      samp(sel, 1'b1, ch, d);
      tick();
      samp(sel, 1'b0, 4'h0, 12'h000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, pulses;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
      samp(0, 0, 0, 0);     samp(1, 0, 0, 0);
      repeat (3) tick();
      check("reset do_out dut0", 32'(drp0.do_out), 32'h0);
      check("reset drdy dut0", 32'(drp0.drdy_out), 32'h0);
      check("reset do_out dut1", 32'(drp1.do_out), 32'h0);
      check("reset drdy dut1", 32'(drp1.drdy_out), 32'h0);
      reset = 1'b0;

      // Basic sample readback and write-then-read
      load(0, 4'd3, 12'hABC);
      txn(0, 0, 7'h13, 0, 16'hABC0, 4, "read vaux3");
      tick();
      txn(0, 1, 7'h41, 16'h1234, 16'h0000, 4, "write cfg1");
      txn(0, 0, 7'h41, 0, 16'h1234, 4, "read cfg1");
      tick();

      // Sample arriving the cycle after acceptance must not change the response
      drive(0, 1, 0, 7'h1B, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      samp(0, 1, 4'd11, 12'hFFF);
      tick();
      samp(0, 0, 0, 0);
      n = 2;
      while (!drdy(0) && n < 32) begin tick(); n++; end
      check("snapshot latency", 32'(n), 32'd4);
      check("snapshot old value", 32'(drp0.do_out), 32'h0000);
      txn(0, 0, 7'h1B, 0, 16'hFFF0, 4, "read vaux11");

      // Same-cycle sample vs. request: request sees the old value; different registers both land
      txn(0, 0, 7'h1A, 0, 16'h0000, 4, "same-cycle sample", 1'b1, 4'd10, 12'h555);
      txn(0, 0, 7'h1A, 0, 16'h5550, 4, "read vaux10");
      txn(0, 1, 7'h40, 16'hBEEF, 16'h0000, 4, "write cfg0 with sample", 1'b1, 4'd5, 12'h0F0);
      txn(0, 0, 7'h40, 0, 16'hBEEF, 4, "read cfg0");
      txn(0, 0, 7'h15, 0, 16'h0F00, 4, "read vaux5");
      txn(0, 1, 7'h13, 16'hFFFF, 16'h0000, 4, "write vaux3 dropped");
      txn(0, 0, 7'h13, 0, 16'hABC0, 4, "read vaux3 unchanged");
      txn(0, 0, 7'h3F, 0, 16'h0000, 4, "status clean");
      tick();

      // Two overlap pulses during BUSY
      drive(0, 1, 0, 7'h13, 0); tick();
      drive(0, 1, 0, 7'h13, 0); tick();
      drive(0, 0, 0, 0, 0);     tick();
      drive(0, 1, 0, 7'h13, 0); tick();
      drive(0, 0, 0, 0, 0);
      check("overlap run drdy", 32'(drp0.drdy_out), 32'h1);
      check("overlap run data", 32'(drp0.do_out), 32'hABC0);
      tick();
      txn(0, 0, 7'h3F, 0, 16'h0201, 4, "status after overlap");
      txn(0, 1, 7'h3F, 16'h0001, 16'h0000, 4, "status clear");
      txn(0, 0, 7'h3F, 0, 16'h0000, 4, "status cleared");
      tick();

      // Back-to-back requests issued in each completion cycle
      txn(0, 0, 7'h13, 0, 16'hABC0, 4, "b2b 0x13");
      txn(0, 0, 7'h1B, 0, 16'hFFF0, 4, "b2b 0x1B");
      txn(0, 0, 7'h55, 0, 16'h0000, 4, "b2b 0x55");
      txn(0, 0, 7'h3F, 0, 16'h0000, 4, "b2b status");
      tick();

      // Held den_in: three overlaps per transaction, count saturates at 255
      drive(0, 1, 0, 7'h55, 0);
      repeat (400) tick();
      drive(0, 0, 0, 0, 0);
      repeat (8) tick();
      txn(0, 0, 7'h3F, 0, 16'hFF01, 4, "status saturated");
      txn(0, 1, 7'h3F, 16'h0001, 16'h0000, 4, "status clear 2");
      tick();

      // Reset two cycles into a read aborts it and clears every register
      drive(0, 1, 0, 7'h13, 0); tick();
      drive(0, 0, 0, 0, 0);     tick();
      reset = 1'b1;             tick();
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (drp0.drdy_out) pulses++;
         tick();
      end
      check("reset abort no drdy", 32'(pulses), 32'h0);
      txn(0, 0, 7'h13, 0, 16'h0000, 4, "post-reset vaux3");
      txn(0, 0, 7'h41, 0, 16'h0000, 4, "post-reset cfg1");
      txn(0, 0, 7'h40, 0, 16'h0000, 4, "post-reset cfg0");
      txn(0, 0, 7'h3F, 0, 16'h0000, 4, "post-reset status");
      tick();

      // LATENCY=1 instance
      load(1, 4'd3, 12'h123);
      txn(1, 0, 7'h13, 0, 16'h1230, 1, "lat1 read vaux3");
      txn(1, 1, 7'h42, 16'h00AA, 16'h0000, 1, "lat1 write cfg2");
      txn(1, 0, 7'h42, 0, 16'h00AA, 1, "lat1 read cfg2");
      txn(1, 0, 7'h3F, 0, 16'h0000, 1, "lat1 status");
      tick();
      check("lat1 drdy single pulse", 32'(drp1.drdy_out), 32'h0);
      check("lat1 do_out held", 32'(drp1.do_out), 32'h0000);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
